// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin register-file write-port arbiter with one-cycle registered write.
// Optional RF_ARB_PROTECT_EN blocks writes to constant registers 6/7 and flags a sticky err_o.
module rf_write_arbiter #(
  parameter int addr_width_p = 4,
  parameter int num_req_p = 3
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [num_req_p-1:0]              req_i,
  input  logic [num_req_p*addr_width_p-1:0] addr_i,
  input  logic [num_req_p*8-1:0]            data_i,
  input  logic [num_req_p-1:0]              oen_i,
  input  logic [num_req_p-1:0]              ovf_i,
  input  logic                              stall_i,
  output logic [num_req_p-1:0]              gnt_o,
  output logic                              wen_o,
  output logic [addr_width_p-1:0]           rd_addr_o,
  output logic [7:0]                        write_data_o,
  output logic                              oen_o,
  output logic                              overflow_o,
  output logic                              err_o
);
  localparam int rw = num_req_p > 1 ? $clog2(num_req_p) : 1;
  logic [rw-1:0] rr_q, sel;
  logic any, g_oen, g_ovf, wr_ok;
  logic [addr_width_p-1:0] g_addr;
  logic [7:0] g_data;
  int j;
  // first requester at or above rr_q (wrapping) wins; reset and stall suppress grants
  always_comb begin
    gnt_o = '0;
    sel = '0;
    any = 1'b0;
    g_addr = '0;
    g_data = '0;
    g_oen = 1'b0;
    g_ovf = 1'b0;
    j = 0;
    for (int i = 0; i < num_req_p; i++) begin
      j = (int'(rr_q) + i) % num_req_p;
      if (!any && req_i[j] && !stall_i && RST_N) begin
        any = 1'b1;
        sel = rw'(j);
        gnt_o[j] = 1'b1;
        g_addr = addr_i[j*addr_width_p +: addr_width_p];
        g_data = data_i[j*8 +: 8];
        g_oen = oen_i[j];
        g_ovf = ovf_i[j];
      end
    end
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      rr_q <= '0;
      wen_o <= 1'b0;
      oen_o <= 1'b0;
      overflow_o <= 1'b0;
      rd_addr_o <= '0;
      write_data_o <= '0;
    end else begin
      wen_o <= any && wr_ok;
      oen_o <= any && g_oen;
      if (any) begin
        rr_q <= (sel == rw'(num_req_p - 1)) ? '0 : sel + 1'b1;
        rd_addr_o <= g_addr;
        write_data_o <= g_data;
        overflow_o <= g_ovf;
      end
    end
`ifdef RF_ARB_PROTECT_EN
  logic prot;
  assign prot = (g_addr == addr_width_p'(6)) || (g_addr == addr_width_p'(7));
  assign wr_ok = !prot;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) err_o <= 1'b0;
    else if (any && prot) err_o <= 1'b1;
`else
  assign wr_ok = 1'b1;
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vector table plus reset/protect sequences for rf_write_arbiter.
module tb_rf_write_arbiter;
  logic CLK = 1'b0, RST_N = 1'b0, stall = 1'b0;
  logic [2:0] req = '0, oen = '0, ovf = '0, gnt;
  logic [11:0] addr = '0;
  logic [23:0] data = '0;
  logic wen, oen_q, ovf_q, err;
  logic [3:0] rd_addr;
  logic [7:0] wdata;
  int passed = 0, total = 0;

  typedef struct {
    logic [2:0] req; logic [11:0] addr; logic [23:0] data; logic [2:0] oen, ovf; logic stall;
    logic [2:0] gnt; logic wen; logic [3:0] ea; logic [7:0] ed; logic eo, ev;
  } vec_t;
  vec_t v[15];

  rf_write_arbiter #(.addr_width_p(4), .num_req_p(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_i(req), .addr_i(addr), .data_i(data), .oen_i(oen), .ovf_i(ovf),
    .stall_i(stall), .gnt_o(gnt), .wen_o(wen), .rd_addr_o(rd_addr), .write_data_o(wdata),
    .oen_o(oen_q), .overflow_o(ovf_q), .err_o(err));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] r, input logic [11:0] a, input logic [23:0] d,
                       input logic [2:0] o, input logic [2:0] f, input logic s);
    req = r; addr = a; data = d; oen = o; ovf = f; stall = s;
  endtask

  initial begin
    v[0]  = '{3'b111, 12'h321, 24'h332211, 3'b000, 3'b000, 1'b0, 3'b001, 1'b1, 4'h1, 8'h11, 1'b0, 1'b0};
    v[1]  = '{3'b111, 12'h321, 24'h332211, 3'b000, 3'b000, 1'b0, 3'b010, 1'b1, 4'h2, 8'h22, 1'b0, 1'b0};
    v[2]  = '{3'b111, 12'h321, 24'h332211, 3'b000, 3'b000, 1'b0, 3'b100, 1'b1, 4'h3, 8'h33, 1'b0, 1'b0};
    v[3]  = '{3'b111, 12'h321, 24'h332211, 3'b000, 3'b000, 1'b0, 3'b001, 1'b1, 4'h1, 8'h11, 1'b0, 1'b0};
    v[4]  = '{3'b000, 12'h321, 24'h332211, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 4'h1, 8'h11, 1'b0, 1'b0};
    v[5]  = '{3'b010, 12'h040, 24'h00A500, 3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 4'h4, 8'hA5, 1'b1, 1'b1};
    v[6]  = '{3'b100, 12'h800, 24'h880000, 3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 4'h8, 8'h88, 1'b1, 1'b0};
    v[7]  = '{3'b101, 12'h905, 24'h990055, 3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 4'h8, 8'h88, 1'b0, 1'b0};
    v[8]  = v[7];
    v[9]  = v[7];
    v[10] = '{3'b101, 12'h905, 24'h990055, 3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 4'h5, 8'h55, 1'b1, 1'b0};
    v[11] = '{3'b100, 12'h905, 24'h990055, 3'b001, 3'b000, 1'b0, 3'b100, 1'b1, 4'h9, 8'h99, 1'b0, 1'b0};
    v[12] = '{3'b101, 12'h905, 24'h990055, 3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 4'h5, 8'h55, 1'b1, 1'b0};
    v[13] = '{3'b100, 12'h905, 24'h990055, 3'b001, 3'b000, 1'b0, 3'b100, 1'b1, 4'h9, 8'h99, 1'b0, 1'b0};
    v[14] = '{3'b000, 12'h905, 24'h990055, 3'b001, 3'b000, 1'b0, 3'b000, 1'b0, 4'h9, 8'h99, 1'b0, 1'b0};
    // reset holds everything at zero even with requests pending
    drive(3'b111, 12'h321, 24'h332211, 3'b111, 3'b111, 1'b0);
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_data", 32'(wdata), 0);
    chk("rst_oen", 32'(oen_q), 0);
    chk("rst_ovf", 32'(ovf_q), 0);
    chk("rst_err", 32'(err), 0);
    req = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      drive(v[i].req, v[i].addr, v[i].data, v[i].oen, v[i].ovf, v[i].stall);
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v[i].gnt));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_wen", i), 32'(wen), 32'(v[i].wen));
      chk($sformatf("v%0d_addr", i), 32'(rd_addr), 32'(v[i].ea));
      chk($sformatf("v%0d_data", i), 32'(wdata), 32'(v[i].ed));
      chk($sformatf("v%0d_oen", i), 32'(oen_q), 32'(v[i].eo));
      chk($sformatf("v%0d_ovf", i), 32'(ovf_q), 32'(v[i].ev));
    end
    // write to constant register 7 (rr_q is 0 here)
    @(negedge CLK);
    drive(3'b001, 12'h007, 24'h0000FF, 3'b001, 3'b000, 1'b0);
    #1;
    chk("p7_gnt", 32'(gnt), 32'b001);
    @(posedge CLK);
    #1;
`ifdef RF_ARB_PROTECT_EN
    chk("p7_wen", 32'(wen), 0);
    chk("p7_err", 32'(err), 1);
`else
    chk("p7_wen", 32'(wen), 1);
    chk("p7_err", 32'(err), 0);
`endif
    chk("p7_addr", 32'(rd_addr), 32'h7);
    chk("p7_data", 32'(wdata), 32'hFF);
    chk("p7_oen", 32'(oen_q), 1);
    @(negedge CLK);
    req = '0;
    @(posedge CLK);
    #1;
    chk("p7_idle_wen", 32'(wen), 0);
`ifdef RF_ARB_PROTECT_EN
    chk("p7_sticky_err", 32'(err), 1);
`else
    chk("p7_sticky_err", 32'(err), 0);
`endif
    // grant to requester 1, then reset while its write is on the outputs
    @(negedge CLK);
    drive(3'b010, 12'h030, 24'h00C300, 3'b010, 3'b000, 1'b0);
    #1;
    chk("mid_gnt", 32'(gnt), 32'b010);
    @(posedge CLK);
    #1;
    chk("mid_wen", 32'(wen), 1);
    chk("mid_addr", 32'(rd_addr), 32'h3);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(wen), 0);
    chk("mid_rst_addr", 32'(rd_addr), 0);
    chk("mid_rst_data", 32'(wdata), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_err", 32'(err), 0);
    req = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst_wen", 32'(wen), 0);
    @(negedge CLK);
    drive(3'b110, 12'h560, 24'h665500, 3'b000, 3'b000, 1'b0);
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'b010);
    @(posedge CLK);
    #1;
    chk("post_rst_addr", 32'(rd_addr), 32'h6);
    chk("post_rst_data", 32'(wdata), 32'h55);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: addr_width_p, 4, register-file address width.
REQ-002 Parameter: num_req_p, 3, number of write requesters (0=ALU, 1=load unit, 2=system/counter updater).
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  num_req_p  per-requester write request, held until granted.
REQ-006 addr_i  input  num_req_p*addr_width_p  per-requester destination register, packed, requester 0 in LSBs.
REQ-007 data_i  input  num_req_p*8  per-requester write data, packed.
REQ-008 oen_i  input  num_req_p  per-requester overflow-flag update enable.
REQ-009 ovf_i  input  num_req_p  per-requester overflow value.
REQ-010 stall_i  input  1  freeze: no grants issued while high.
REQ-011 gnt_o  output  num_req_p  one-hot grant pulse, combinational from current state and inputs.
REQ-012 wen_o  output  1  registered register-file write enable.
REQ-013 rd_addr_o  output  addr_width_p  registered write address.
REQ-014 write_data_o  output  8  registered write data.
REQ-015 oen_o / overflow_o  output  1 each  registered overflow enable and value.
REQ-016 err_o  output  1  sticky protected-write error flag (RF_ARB_PROTECT_EN only; tied 0 otherwise).

Function
REQ-017 Handshake: requester holds req_i, addr, data, oen, ovf stable until its gnt_o bit is 1; the grant cycle completes the transfer; requester may present a new request in the following cycle.
REQ-018 At most one gnt_o bit SHALL be high per cycle; gnt_o SHALL be all zero when stall_i=1 or no req_i bit is set.
REQ-019 Arbitration: round-robin; search starts at pointer rr_q and proceeds upward with wrap-around to 0; first requesting index wins.
REQ-020 After a grant to index k, rr_q SHALL become (k+1) mod num_req_p on the next edge; otherwise rr_q holds.
REQ-021 Latency: granted request appears on wen_o/rd_addr_o/write_data_o/oen_o/overflow_o exactly one cycle after the grant cycle, for exactly one cycle.
REQ-022 In cycles with no grant, wen_o and oen_o SHALL be 0; rd_addr_o, write_data_o, overflow_o hold last values.
REQ-023 A request withdrawn before grant is discarded; no output activity results.
REQ-024 stall_i asserted in the same cycle as a pending request: no grant, rr_q unchanged; arbitration resumes the cycle stall_i falls.
REQ-025 oen_o SHALL equal granted requester's oen_i bit, independent of the write being protected.
REQ-026 Back-to-back grants on consecutive cycles SHALL be supported (one write per cycle throughput).

Reset
REQ-027 RST_N low SHALL immediately clear wen_o, oen_o, overflow_o, rd_addr_o, write_data_o, err_o, rr_q to 0 and force gnt_o to 0.
REQ-028 Reset mid-transfer: a grant in progress is lost; no write issues after RST_N rises until a fresh grant.
REQ-029 First grant after reset SHALL search from index 0.

Configuration
REQ-030 Macro RF_ARB_PROTECT_EN: when defined, a granted write to address 6 or 7 (constant registers) is acknowledged but issues wen_o=0 and sets err_o=1 until reset.
REQ-031 Without RF_ARB_PROTECT_EN, writes to 6/7 are forwarded with wen_o=1 and err_o is constant 0.

Verification
REQ-032 Reset then req_i=3'b111 held, addresses 1,2,3 -> gnt_o 001,010,100,001 on successive cycles; wen_o writes 1,2,3 one cycle each later.
REQ-033 req_i=3'b010, addr 4, data 8'hA5, oen=1, ovf=1 -> gnt_o=010 cycle N; cycle N+1 wen_o=1, rd_addr_o=4, write_data_o=8'hA5, oen_o=1, overflow_o=1; cycle N+2 wen_o=0.
REQ-034 req_i=3'b101 with stall_i=1 for 3 cycles -> gnt_o=0, wen_o=0 throughout; stall_i falls -> gnt_o=001 next evaluation.
REQ-035 Grant to index 2 then req_i=3'b101 -> wrap-around: gnt_o=001 before 100.
REQ-036 With RF_ARB_PROTECT_EN, write to addr 7 data 8'hFF -> gnt pulse, wen_o=0, err_o=1 sticky until RST_N low; without macro -> wen_o=1, addr 7, err_o=0.
REQ-037 RST_N pulsed low the cycle after a grant -> wen_o=0 immediately, no write after release, next grant from index 0.
